sync_bypass_fifo_core: RTL and testbench
========================================

// Module: sync_bypass_fifo_core
// PURPOSE
//   Single-clock FIFO of 2**ADDR_WIDTH words with a registered read port and an
//   optional empty-queue bypass. Used in the RS decoder Forney path to buffer
//   error positions/values between producer and consumer stages.
//   PASS_THRU=1: a push and pull on an empty FIFO hands data_in straight to
//   data_out without occupying storage.
// PARAMETERS
//   PASS_THRU   0    1 = enable empty-FIFO bypass; 0 = plain FIFO
//   ADDR_WIDTH  4    pointer width; depth DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  32   word width in bits (must work up to at least 128)
// PORTS
//   clk_i     in   1           clock, rising edge
//   rst_ni    in   1           asynchronous active-low reset
//   flush     in   1           synchronous clear of all contents
//   data_in   in   DATA_WIDTH  write data
//   push      in   1           write request
//   full      out  1           DEPTH words stored
//   data_out  out  DATA_WIDTH  read data register
//   pull      in   1           read request
//   empty     out  1           zero words stored
// BEHAVIOUR
//   Reset (rst_ni=0, async): pointers and count = 0, data_out = 0, empty = 1,
//     full = 0.
//   State: wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH),
//     count (ADDR_WIDTH+1 bits).
//   Flag decode, from registered state only:
//     empty = (count == 0); full = (count == DEPTH).
//   pop  = pull & ~empty: at that edge data_out <= mem[rd_ptr]; rd_ptr++.
//     The popped word is visible on data_out just after the edge and holds
//     until the next pop, bypass or flush.
//   push accept = push & ~full: mem[wr_ptr] <= data_in; wr_ptr++.
//   Push while full: ignored, even if pull is also high. No overwrite.
//   Pull while empty (no bypass): ignored; data_out holds.
//   Push+pop in the same cycle when not empty and not full: both occur; count
//     unchanged.
//   Bypass (PASS_THRU=1, empty & push & pull): data_out <= data_in. Nothing is
//     written; pointers and count unchanged; empty stays 1.
//   PASS_THRU=0, empty & push & pull: push is stored (count 0->1); no pop;
//     data_out holds.
//   flush=1: at the edge, wr_ptr = rd_ptr = count = 0 and data_out = 0.
//     Flush overrides push/pull in that cycle. empty = 1 from the next cycle.
//   Ordering is strict FIFO across pointer wrap-around.
//   Reset mid-operation discards all contents immediately.
// CONFIGURATION
//   `SYNC_BYPASS_FIFO_ASSERT_EN defined: simulation assertions are compiled in.
//     They issue $error on push & full & ~flush (overflow attempt) and on
//     pull & empty & ~(PASS_THRU & push) (underflow attempt). They also check
//     count <= DEPTH.
//   Undefined: no assertions; functional behaviour identical.
// STRUCTURE
//   Package sync_bypass_fifo_pkg: function/constant for DEPTH from ADDR_WIDTH;
//     default width constants.
//   Sub-module sync_bypass_fifo_mem: DEPTH x DATA_WIDTH register array, one
//     write port, one read port. No reset on the array.
//   Top level holds pointers, count, flags, data_out register and bypass mux.
// TESTING
//   1. Reset, push 10 words A0..A9, pull 5 -> data_out = A0..A4 in order,
//      each after its pull edge; count 5.
//   2. PASS_THRU=1, empty, push+pull with data_in=128'hDEADBEEF_01234567_
//      89ABCDEF_F00DBABE -> data_out equals it after that edge; empty stays 1.
//   3. PASS_THRU=0, empty, push+pull -> word stored, empty=0 next cycle,
//      data_out unchanged; the next pull returns it.
//   4. Push 16 words (ADDR_WIDTH=4) -> full=1. A 17th push is ignored. Drain
//      16 -> exact order, then empty=1.
//   5. 400 cycles random push/pull (gated by full/empty) vs a queue model ->
//      no data or flag mismatch across wrap.
//   6. Partially filled FIFO, flush pulse -> empty=1 next cycle, data_out=0;
//      the next push/pull returns the new word only.

Source files
------------

// File: rtl/sync_bypass_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_bypass_fifo_pkg
//   Shared constants and helpers for the sync_bypass_fifo_core slice.
//   - DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH: default geometry.
//   - fifo_depth(): number of words for a given pointer width.
//   - fifo_op_e: encoding of the storage operation chosen each cycle. It is
//     used only to make the count update easy to read.
// ---------------------------------------------------------------------------
package sync_bypass_fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Depth is always a power of two, so the pointers wrap naturally.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_bypass_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_bypass_fifo_mem
//   DEPTH x DATA_WIDTH storage array for the FIFO. It has one synchronous
//   write port and one asynchronous read port. The array is not reset, so
//   contents are undefined until they are written. The FIFO never reads a
//   location it has not written.
// Ports
//   clk_i    in   1           clock, rising edge
//   i_we     in   1           write enable
//   i_waddr  in   ADDR_WIDTH  write address
//   i_wdata  in   DATA_WIDTH  write data
//   i_raddr  in   ADDR_WIDTH  read address
//   o_rdata  out  DATA_WIDTH  read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module sync_bypass_fifo_mem
  import sync_bypass_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_bypass_fifo_core.sv
// ---------------------------------------------------------------------------
// sync_bypass_fifo_core
//   Single-clock FIFO of 2**ADDR_WIDTH words. The read data port is
//   registered. An optional empty-queue bypass is selected with PASS_THRU=1.
//   The FIFO buffers error positions and values between the stages of the
//   RS decoder Forney path.
//
// Handshake
//   A write is accepted on a rising edge when push=1 and full=0. A read is
//   accepted when pull=1 and empty=0. The popped word appears on data_out
//   just after that edge and holds there until the next pop, bypass or
//   flush. A request that is not accepted is dropped, not held. When
//   PASS_THRU=1 and the FIFO is empty, push+pull together moves data_in
//   straight to data_out and touches no storage.
//
// Ports
//   clk_i     in   1           clock, rising edge
//   rst_ni    in   1           asynchronous active-low reset
//   flush     in   1           synchronous clear (overrides push/pull)
//   data_in   in   DATA_WIDTH  write data
//   push      in   1           write request
//   full      out  1           DEPTH words stored
//   data_out  out  DATA_WIDTH  read data register
//   pull      in   1           read request
//   empty     out  1           zero words stored
//
// Configuration
//   SYNC_BYPASS_FIFO_ASSERT_EN : when defined, simulation checks for
//   overflow and underflow attempts and for count range are compiled in.
// ---------------------------------------------------------------------------
module sync_bypass_fifo_core
  import sync_bypass_fifo_pkg::*;
#(
  parameter int unsigned PASS_THRU  = 0,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pull,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(fifo_depth(ADDR_WIDTH));
  localparam bit                  BYPASS_EN = (PASS_THRU != 0);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_pop;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rdata;
  fifo_op_e              w_op;

  // Flags come from registered state only, so they never depend
  // combinationally on push or pull.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_CNT);

  // The bypass applies only when the FIFO is empty. It is therefore
  // mutually exclusive with a real pop.
  assign w_bypass = BYPASS_EN & w_empty & push & pull;
  assign w_pop    = pull & ~w_empty & ~flush;
  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_wr_en  = push & ~w_full & ~w_bypass & ~flush;
  assign w_op     = fifo_op_e'({w_wr_en, w_pop});

  sync_bypass_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rdata;
      end else if (w_bypass) begin
        r_data_out <= data_in;
      end
      case (w_op)
        OP_PUSH: r_count <= r_count + 1'b1;
        OP_POP:  r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign data_out = r_data_out;

`ifdef SYNC_BYPASS_FIFO_ASSERT_EN
  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (push && w_full && !flush) begin
        $error("sync_bypass_fifo_core: overflow attempt (push while full)");
      end
      if (pull && w_empty && !(BYPASS_EN && push)) begin
        $error("sync_bypass_fifo_core: underflow attempt (pull while empty)");
      end
      if (r_count > DEPTH_CNT) begin
        $error("sync_bypass_fifo_core: count %0d exceeds depth", r_count);
      end
    end
  end
`else
  // No simulation checks compiled in. The behaviour is unchanged.
`endif

endmodule

// File: tb/tb_sync_bypass_fifo_core.sv
module tb_sync_bypass_fifo_core;

  localparam int AW = 4;
  localparam int DW = 128;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          push  = 1'b0;
  logic          pull  = 1'b0;
  logic [DW-1:0] din   = '0;

  logic          full0, empty0, full1, empty1;
  logic [DW-1:0] dout0, dout1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dout;

  sync_bypass_fifo_core #(.PASS_THRU(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush(flush), .data_in(din), .push(push),
    .full(full0), .data_out(dout0), .pull(pull), .empty(empty0)
  );

  sync_bypass_fifo_core #(.PASS_THRU(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush(flush), .data_in(din), .push(push),
    .full(full1), .data_out(dout1), .pull(pull), .empty(empty1)
  );

  // One clock edge. Outputs are settled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 1'b0; pull = 1'b0; flush = 1'b0; din = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty0 got=%b exp=1", empty0); end
    checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full0 got=%b exp=0", full0); end
    checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_dout0 got=%h exp=0", dout0); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty1 got=%b exp=1", empty1); end
    checks++; if (full1 !== 1'b0) begin errors++; $display("FAIL reset_full1 got=%b exp=0", full1); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL reset_dout1 got=%h exp=0", dout1); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_pull();
    logic [DW-1:0] e;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; din = DW'('hA0 + i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      pull = 1'b1;
      step();
      e = DW'('hA0 + i);
      checks++; if (dout0 !== e) begin errors++; $display("FAIL fill_pull_dout0[%0d] got=%h exp=%h", i, dout0, e); end
      checks++; if (dout1 !== e) begin errors++; $display("FAIL fill_pull_dout1[%0d] got=%h exp=%h", i, dout1, e); end
      if (i == 4) begin
        // five words still stored
        checks++; if (empty0 !== 1'b0 || full0 !== 1'b0) begin errors++; $display("FAIL fill_pull_count5_flags0 got=%b%b exp=00", empty0, full0); end
        checks++; if (empty1 !== 1'b0 || full1 !== 1'b0) begin errors++; $display("FAIL fill_pull_count5_flags1 got=%b%b exp=00", empty1, full1); end
      end
    end
    pull = 1'b0;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL fill_pull_drained0 got=%b exp=1", empty0); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fill_pull_drained1 got=%b exp=1", empty1); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] w;
    w = 128'hDEADBEEF_01234567_89ABCDEF_F00DBABE;
    push = 1'b1; pull = 1'b1; din = w;
    step();
    idle_inputs();
    // PASS_THRU=1: handed straight through, nothing stored
    checks++; if (dout1 !== w) begin errors++; $display("FAIL bypass_dout1 got=%h exp=%h", dout1, w); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL bypass_empty1 got=%b exp=1", empty1); end
    // PASS_THRU=0: stored, data_out holds the last popped word (A9)
    checks++; if (dout0 !== DW'('hA9)) begin errors++; $display("FAIL nobypass_dout0_hold got=%h exp=a9", dout0); end
    checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL nobypass_empty0 got=%b exp=0", empty0); end
    pull = 1'b1;
    step();
    pull = 1'b0;
    checks++; if (dout0 !== w) begin errors++; $display("FAIL nobypass_pull_dout0 got=%h exp=%h", dout0, w); end
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL nobypass_after_empty0 got=%b exp=1", empty0); end
    // pull on empty PASS_THRU instance without push is ignored
    checks++; if (dout1 !== w) begin errors++; $display("FAIL bypass_hold_dout1 got=%h exp=%h", dout1, w); end
  endtask

  task automatic test_full();
    logic [DW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1; din = DW'('hB0 + i);
      step();
      if (i == DEPTH - 2) begin
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL full_at15_0 got=%b exp=0", full0); end
      end
    end
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL full_at16_0 got=%b exp=1", full0); end
    checks++; if (full1 !== 1'b1) begin errors++; $display("FAIL full_at16_1 got=%b exp=1", full1); end
    // 17th push is ignored
    push = 1'b1; din = DW'('hFF);
    step();
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL full_17th_0 got=%b exp=1", full0); end
    // push+pull while full: pop happens, push dropped
    push = 1'b1; pull = 1'b1; din = DW'('hEE);
    step();
    idle_inputs();
    checks++; if (dout0 !== DW'('hB0)) begin errors++; $display("FAIL full_pushpull_dout0 got=%h exp=b0", dout0); end
    checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL full_pushpull_full0 got=%b exp=0", full0); end
    for (int i = 1; i < DEPTH; i++) begin
      pull = 1'b1;
      step();
      e = DW'('hB0 + i);
      checks++; if (dout0 !== e) begin errors++; $display("FAIL drain_dout0[%0d] got=%h exp=%h", i, dout0, e); end
      checks++; if (dout1 !== e) begin errors++; $display("FAIL drain_dout1[%0d] got=%h exp=%h", i, dout1, e); end
    end
    pull = 1'b0;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL drain_empty0 got=%b exp=1", empty0); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL drain_empty1 got=%b exp=1", empty1); end
    last_dout = DW'('hBF);
  endtask

  task automatic test_random();
    bit p, q;
    exp_q.delete();
    for (int cyc = 0; cyc < 400 + 20; cyc++) begin
      // final 20 cycles only drain
      p = (cyc < 400) && ($urandom_range(0, 1) == 1) && (exp_q.size() < DEPTH);
      q = ($urandom_range(0, 1) == 1 || cyc >= 400) && (exp_q.size() > 0);
      push = p; pull = q;
      din = {$urandom, $urandom, $urandom, $urandom};
      if (q) last_dout = exp_q.pop_front();
      if (p) exp_q.push_back(din);
      step();
      checks++; if (dout0 !== last_dout) begin errors++; $display("FAIL rand_dout0 cyc=%0d got=%h exp=%h", cyc, dout0, last_dout); end
      checks++; if (dout1 !== last_dout) begin errors++; $display("FAIL rand_dout1 cyc=%0d got=%h exp=%h", cyc, dout1, last_dout); end
      checks++; if (empty0 !== (exp_q.size() == 0)) begin errors++; $display("FAIL rand_empty0 cyc=%0d got=%b exp=%b", cyc, empty0, exp_q.size() == 0); end
      checks++; if (full0 !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full0 cyc=%0d got=%b exp=%b", cyc, full0, exp_q.size() == DEPTH); end
      checks++; if (empty1 !== (exp_q.size() == 0)) begin errors++; $display("FAIL rand_empty1 cyc=%0d got=%b exp=%b", cyc, empty1, exp_q.size() == 0); end
      checks++; if (full1 !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full1 cyc=%0d got=%b exp=%b", cyc, full1, exp_q.size() == DEPTH); end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = DW'('hC0 + i);
      step();
    end
    push = 1'b0; pull = 1'b1;
    step();
    checks++; if (dout0 !== DW'('hC0)) begin errors++; $display("FAIL flush_pre_dout0 got=%h exp=c0", dout0); end
    // flush overrides a simultaneous push+pull
    flush = 1'b1; push = 1'b1; pull = 1'b1; din = DW'('hDD);
    step();
    idle_inputs();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL flush_empty0 got=%b exp=1", empty0); end
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL flush_empty1 got=%b exp=1", empty1); end
    checks++; if (dout0 !== '0) begin errors++; $display("FAIL flush_dout0 got=%h exp=0", dout0); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL flush_dout1 got=%h exp=0", dout1); end
    push = 1'b1; din = DW'('hC9);
    step();
    push = 1'b0; pull = 1'b1;
    step();
    pull = 1'b0;
    checks++; if (dout0 !== DW'('hC9)) begin errors++; $display("FAIL flush_new_dout0 got=%h exp=c9", dout0); end
    checks++; if (dout1 !== DW'('hC9)) begin errors++; $display("FAIL flush_new_dout1 got=%h exp=c9", dout1); end
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL flush_new_empty0 got=%b exp=1", empty0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; din = DW'('hE0 + i);
      step();
    end
    pull = 1'b1; push = 1'b0;
    step();
    idle_inputs();
    // asynchronous: takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rstmid_empty0 got=%b exp=1", empty0); end
    checks++; if (dout0 !== '0) begin errors++; $display("FAIL rstmid_dout0 got=%h exp=0", dout0); end
    checks++; if (dout1 !== '0) begin errors++; $display("FAIL rstmid_dout1 got=%h exp=0", dout1); end
    step();
    rst_n = 1'b1;
    push = 1'b1; din = DW'('hE7);
    step();
    push = 1'b0; pull = 1'b1;
    step();
    pull = 1'b0;
    checks++; if (dout0 !== DW'('hE7)) begin errors++; $display("FAIL rstmid_new_dout0 got=%h exp=e7", dout0); end
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rstmid_new_empty0 got=%b exp=1", empty0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill_pull();
    test_bypass();
    test_full();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
